// File: rtl/hack_pkg.sv
// Shared defaults and the queue entry layout for the Hack instruction fetch path.
package hack_pkg;

   localparam int unsigned DEF_DATA_W   = 16;
   localparam int unsigned DEF_ADDR_W   = 15;
   localparam int unsigned DEF_RESET_PC = 0;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] instr;
      logic [DEF_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/hack_fifo_ram.sv
// DEPTH-entry register array for the fetch queue: one write port, one
// combinational read port, and a synchronous whole-array clear.
module hack_fifo_ram #(
   parameter int unsigned WIDTH = 31,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hack_fetch_queue.sv
// Instruction prefetch queue between the 1-cycle synchronous ROM and the Hack CPU,
// with jump flush and cancellation of the in-flight ROM word.
module hack_fetch_queue
   import hack_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic [ADDR_W-1:0]          rom_addr,
   output logic                       rom_rd,
   input  logic [DATA_W-1:0]          rom_data,
   input  logic                       pop,
   input  logic                       jmp,
   input  logic [ADDR_W-1:0]          jmp_addr,
   output logic [DATA_W-1:0]          instruction,
   output logic [ADDR_W-1:0]          instr_pc,
   output logic                       instr_valid,
   output logic                       stall,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ENT_W = DATA_W + ADDR_W;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [LVL_W-1:0]  count;

   logic              pop_ok;
   logic              refill;
   logic              issue;
   logic [LVL_W-1:0]  occ_next;
   logic [LVL_W-1:0]  count_next;
   logic [PTR_W-1:0]  head_next;
   logic [ENT_W-1:0]  new_entry;
   logic [ENT_W-1:0]  rd_entry;
   logic [ENT_W-1:0]  head_entry_next;

   always_comb begin
      pop_ok     = pop & instr_valid & ~jmp;
      refill     = inflight & ~jmp;
      // The returning word is the only outstanding read, so occupancy after
      // this edge bounds whether another issue still fits.
      occ_next   = count + LVL_W'(refill) - LVL_W'(pop_ok);
      issue      = ~reset & ~jmp & (occ_next < LVL_W'(DEPTH));
      count_next = jmp ? '0 : occ_next;
      head_next  = head + PTR_W'(pop_ok);
      new_entry  = {rom_data, inflight_pc};
      // A word landing in a queue that is empty after this pop bypasses the array.
      if (refill && ((count - LVL_W'(pop_ok)) == '0)) head_entry_next = new_entry;
      else                                            head_entry_next = rd_entry;
   end

   hack_fifo_ram #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .clr   (jmp),
      .we    (refill),
      .waddr (tail),
      .wdata (new_entry),
      .raddr (head_next),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= ADDR_W'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= ADDR_W'(RESET_PC);
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         instr_valid <= 1'b0;
         instruction <= '0;
         instr_pc    <= ADDR_W'(RESET_PC);
      end else begin
         if (jmp)        fetch_pc <= jmp_addr;
         else if (issue) fetch_pc <= fetch_pc + ADDR_W'(1);
         inflight <= issue;
         if (issue) inflight_pc <= fetch_pc;
         if (jmp) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head_next;
            if (refill) tail <= tail + PTR_W'(1);
         end
         count       <= count_next;
         instr_valid <= (count_next != '0);
         if (count_next != '0) {instruction, instr_pc} <= head_entry_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && refill) assert (count < LVL_W'(DEPTH));
   end

   assign rom_addr = fetch_pc;
   assign rom_rd   = issue;
   assign stall    = ~instr_valid;
   assign level    = count;

endmodule

// File: tb/tb_hack_fetch_queue.sv
// Self-checking bench for hack_fetch_queue: queue-based reference model plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_hack_fetch_queue;
   import hack_pkg::*;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 15;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned RST_PC = 0;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_rd;
   logic [DATA_W-1:0] rom_data = '0;
   logic              pop = 1'b0;
   logic              jmp = 1'b0;
   logic [ADDR_W-1:0] jmp_addr = '0;
   logic [DATA_W-1:0] instruction;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              stall;
   logic [$clog2(DEPTH):0] level;

   int n_cmp = 0;
   int n_bad = 0;

   hack_fetch_queue #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_rd      (rom_rd),
      .rom_data    (rom_data),
      .pop         (pop),
      .jmp         (jmp),
      .jmp_addr    (jmp_addr),
      .instruction (instruction),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .stall       (stall),
      .level       (level)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) + 16'h0100;
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge clk) rom_data <= rom_word(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of fetched entries, one optional pending read, fetch pointer.
   fetch_entry_t      mq[$];
   bit                m_pend = 1'b0;
   logic [ADDR_W-1:0] m_pend_pc = '0;
   logic [ADDR_W-1:0] m_fpc = ADDR_W'(RST_PC);

   always @(negedge clk) begin
      if (reset) begin
         mq.delete();
         m_pend = 1'b0;
         m_fpc  = ADDR_W'(RST_PC);
         chk("rst_level", 32'(level), 0);
         chk("rst_valid", 32'(instr_valid), 0);
         chk("rst_stall", 32'(stall), 1);
         chk("rst_rom_rd", 32'(rom_rd), 0);
         chk("rst_rom_addr", 32'(rom_addr), RST_PC);
      end else begin
         int  sz;
         bit  pop_eff;
         bit  exp_rd;
         fetch_entry_t e;
         sz = mq.size();
         chk("m_level", 32'(level), 32'(sz));
         chk("m_valid", 32'(instr_valid), 32'(sz > 0));
         chk("m_stall", 32'(stall), 32'(sz == 0));
         if (sz > 0) begin
            chk("m_pc", 32'(instr_pc), 32'(mq[0].pc));
            chk("m_instr", 32'(instruction), 32'(mq[0].instr));
         end
         pop_eff = pop && (sz > 0);
         exp_rd  = !jmp && ((sz + int'(m_pend) - int'(pop_eff)) < int'(DEPTH));
         chk("m_rom_rd", 32'(rom_rd), 32'(exp_rd));
         chk("m_rom_addr", 32'(rom_addr), 32'(m_fpc));
         if (jmp) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = jmp_addr;
         end else begin
            if (pop_eff) void'(mq.pop_front());
            if (m_pend) begin
               e.pc    = m_pend_pc;
               e.instr = rom_word(m_pend_pc);
               mq.push_back(e);
            end
            m_pend    = exp_rd;
            m_pend_pc = m_fpc;
            if (exp_rd) m_fpc = m_fpc + ADDR_W'(1);
         end
      end
   end

   task automatic edge_then_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic p, input logic j, input logic [ADDR_W-1:0] a);
      #1;
      pop = p;
      jmp = j;
      jmp_addr = a;
   endtask

   task automatic restart(input logic p);
      reset = 1'b1;
      pop = 1'b0;
      jmp = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      pop = p;
   endtask

   initial begin
      // Cold start with pop held high.
      restart(1'b1);
      edge_then_sample();
      chk("s1_not_yet_valid", 32'(instr_valid), 0);
      edge_then_sample();
      chk("s1_valid", 32'(instr_valid), 1);
      chk("s1_instr0", 32'(instruction), 32'h0100);
      chk("s1_pc0", 32'(instr_pc), 0);
      for (int k = 1; k < 6; k++) begin
         edge_then_sample();
         chk("s1_stream_pc", 32'(instr_pc), 32'(k));
         chk("s1_stream_valid", 32'(instr_valid), 1);
      end

      // Backpressure: nothing popped for 10 cycles.
      restart(1'b0);
      repeat (10) edge_then_sample();
      chk("s2_level_full", 32'(level), 4);
      chk("s2_rom_rd_off", 32'(rom_rd), 0);
      chk("s2_fetch_pc", 32'(rom_addr), 4);
      drive(1'b1, 1'b0, '0);
      for (int k = 0; k < 8; k++) begin
         chk("s2_drain_pc", 32'(instr_pc), 32'(k));
         chk("s2_drain_valid", 32'(instr_valid), 1);
         edge_then_sample();
      end

      // Jump flush with level=3 and a read in flight.
      restart(1'b0);
      repeat (4) edge_then_sample();
      drive(1'b0, 1'b1, 15'h0020);
      #1;
      chk("s3_level_before", 32'(level), 3);
      chk("s3_no_issue_on_jmp", 32'(rom_rd), 0);
      edge_then_sample();
      drive(1'b1, 1'b0, '0);
      chk("s3_level_flushed", 32'(level), 0);
      chk("s3_stall", 32'(stall), 1);
      edge_then_sample();
      chk("s3_inflight_dropped", 32'(level), 0);
      edge_then_sample();
      chk("s3_target_pc", 32'(instr_pc), 32'h20);
      chk("s3_target_instr", 32'(instruction), 32'h0120);
      edge_then_sample();
      chk("s3_next_pc", 32'(instr_pc), 32'h21);

      // Jump with pop on a non-empty queue, then back-to-back jumps.
      repeat (2) edge_then_sample();
      drive(1'b1, 1'b1, 15'h0010);
      edge_then_sample();
      drive(1'b1, 1'b1, 15'h0030);
      edge_then_sample();
      drive(1'b1, 1'b0, '0);
      chk("s4_level_flushed", 32'(level), 0);
      edge_then_sample();
      edge_then_sample();
      chk("s4_pc30", 32'(instr_pc), 32'h30);
      chk("s4_instr30", 32'(instruction), 32'h0130);
      edge_then_sample();
      chk("s4_pc31", 32'(instr_pc), 32'h31);

      // Address wrap at the top of the ROM.
      drive(1'b1, 1'b1, 15'h7FFE);
      edge_then_sample();
      drive(1'b1, 1'b0, '0);
      edge_then_sample();
      edge_then_sample();
      chk("s5_pc_7ffe", 32'(instr_pc), 32'h7FFE);
      edge_then_sample();
      chk("s5_pc_7fff", 32'(instr_pc), 32'h7FFF);
      edge_then_sample();
      chk("s5_pc_0000", 32'(instr_pc), 32'h0000);
      chk("s5_instr_0000", 32'(instruction), 32'h0100);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         logic [ADDR_W-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? ADDR_W'(15'h7FFC + $urandom_range(0, 3))
                                         : ADDR_W'($urandom);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, a);
         edge_then_sample();
      end

      // Asynchronous reset between edges.
      drive(1'b1, 1'b0, '0);
      repeat (6) edge_then_sample();
      #2;
      reset = 1'b1;
      #1;
      chk("s6_async_level", 32'(level), 0);
      chk("s6_async_valid", 32'(instr_valid), 0);
      chk("s6_async_stall", 32'(stall), 1);
      restart(1'b1);
      edge_then_sample();
      edge_then_sample();
      chk("s6_restart_pc", 32'(instr_pc), RST_PC);
      chk("s6_restart_instr", 32'(instruction), 32'h0100);
      edge_then_sample();
      chk("s6_restart_pc1", 32'(instr_pc), 1);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, got running expected finished");
      $fatal(1);
   end

endmodule
